mc_control_fsm: RTL and testbench
=================================

MC_CONTROL_FSM -- requirements
Module: mc_control_fsm

Interface
REQ-001 The block SHALL have one clock and an asynchronous active-low reset: clk input 1, rising-edge clock; rst_n input 1, asynchronous active-low reset.
REQ-002 The block SHALL have these decode inputs: opcode input 6, instruction [31:26] from the instruction register; funct input 6, instruction [5:0].
REQ-003 The block SHALL have this ALU status input: flag input 1, ALU zero flag, 1 when the ALU result is 0.
REQ-004 The block SHALL have these ALU control outputs: ALUSrcA output 1 (0=PC, 1=rego1); ALUSrcB output 2 (0=rego2, 1=const 4, 2=sign-extended imm, 3=sign-extended imm<<2); alu_op output 5; ALURegWe output 1, ALU result-latch enable.
REQ-005 The block SHALL have these datapath control outputs: PCWrite output 1; PCSource output 2 (0=ALU out, 1=ALU latch, 2=jump target); IorD output 1; MemRead output 1; MemWrite output 1; IRWrite output 1; MemtoReg output 1; RegDst output 1; RegWrite output 1.
REQ-006 The block SHALL have these status outputs: state output 4, current state code; illegal output 1, one-cycle pulse on an unsupported opcode or funct.

Function
REQ-007 The block SHALL encode alu_op as ADD=5'h00, SUB=5'h01, AND=5'h02, OR=5'h03, SLT=5'h04.
REQ-008 The block SHALL use these states: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RWB=7, BRANCH=8, JUMP=9, IEXEC=10, IWB=11; codes 12-15 SHALL return to FETCH.
REQ-009 All outputs SHALL be combinational decodes of the state register and inputs; an output not listed for a state SHALL be 0.
REQ-010 FETCH SHALL drive MemRead=1, IRWrite=1, IorD=0, ALUSrcA=0, ALUSrcB=1, alu_op=ADD, PCSource=0, PCWrite=1, and SHALL go to DECODE.
REQ-011 DECODE SHALL drive ALUSrcA=0, ALUSrcB=3, alu_op=ADD, ALURegWe=1 to latch the branch target, and SHALL branch on opcode: 0x23 or 0x2B to MEMADR; 0x00 to EXEC; 0x04 to BRANCH; 0x02 to JUMP; 0x08 to IEXEC; any other opcode to FETCH with illegal=1.
REQ-012 MEMADR SHALL drive ALUSrcA=1, ALUSrcB=2, alu_op=ADD, ALURegWe=1, and SHALL go to MEMRD for 0x23 and to MEMWR for 0x2B.
REQ-013 MEMRD SHALL drive MemRead=1, IorD=1 and go to MEMWB; MEMWB SHALL drive RegWrite=1, MemtoReg=1, RegDst=0 and go to FETCH; MEMWR SHALL drive MemWrite=1, IorD=1 and go to FETCH.
REQ-014 EXEC SHALL drive ALUSrcA=1, ALUSrcB=0, ALURegWe=1, and alu_op from funct: 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x2A SLT.
REQ-015 In EXEC, any other funct SHALL pulse illegal and SHALL cause a transition to FETCH with no register write.
REQ-016 RWB SHALL drive RegWrite=1, RegDst=1, MemtoReg=0 and go to FETCH.
REQ-017 BRANCH SHALL drive ALUSrcA=1, ALUSrcB=0, alu_op=SUB, PCSource=1, PCWrite=flag, and go to FETCH.
REQ-018 JUMP SHALL drive PCSource=2, PCWrite=1 and go to FETCH.
REQ-019 IEXEC SHALL drive ALUSrcA=1, ALUSrcB=2, alu_op=ADD, ALURegWe=1 and go to IWB; IWB SHALL drive RegWrite=1, RegDst=0, MemtoReg=0 and go to FETCH.
REQ-020 Cycles per instruction, counted from FETCH entry, SHALL be: lw 5; sw, R-type and addi 4; beq and j 3.

Reset
REQ-021 Asserting rst_n low SHALL force state to FETCH asynchronously, including mid-instruction.
REQ-022 While rst_n is low, PCWrite, MemWrite, RegWrite, IRWrite, ALURegWe and illegal SHALL be 0.
REQ-023 The first FETCH cycle SHALL begin on the first rising clk edge after rst_n deasserts.

Configuration
REQ-024 With BNE_EN defined, opcode 0x05 SHALL decode to BRANCH, and PCWrite in BRANCH SHALL equal ~flag for 0x05 and flag for 0x04.
REQ-025 Without BNE_EN defined, opcode 0x05 SHALL be illegal and SHALL be handled as in REQ-011.

Verification
REQ-026 Reset released, opcode=0x23 -> states 0,1,2,3,4,0; RegWrite=1 and MemtoReg=1 only in state 4.
REQ-027 opcode=0x00, funct=0x22 -> alu_op=5'h01 in EXEC; RegWrite=1 with RegDst=1 in RWB; 4 cycles total.
REQ-028 opcode=0x04 with flag=1, then with flag=0 -> PCWrite=1 with PCSource=1 in BRANCH, then PCWrite=0; 3 cycles each.
REQ-029 opcode=0x3F and, separately, opcode=0x00 with funct=0x3F -> illegal pulses for exactly 1 cycle, next state is FETCH, no RegWrite and no MemWrite.
REQ-030 rst_n pulled low in MEMWR -> state=0 immediately, MemWrite=0, and no write enables are active until release.
REQ-031 opcode=0x05 with flag=0 -> with BNE_EN: PCWrite=1 in BRANCH; without BNE_EN: illegal=1 and return to FETCH.

Source files
------------

// File: rtl/mc_control_fsm_if.sv
// -----------------------------------------------------------------------------
// mc_control_fsm_if
// Bundles the decode inputs, ALU status and all control/status outputs of the
// multi-cycle MIPS-style control FSM.
//
// Signals
//   opcode   [5:0]  instruction[31:26] from the instruction register
//   funct    [5:0]  instruction[5:0]
//   flag            ALU zero flag
//   ALUSrcA         0 = PC, 1 = rego1
//   ALUSrcB  [1:0]  0 = rego2, 1 = const 4, 2 = sext imm, 3 = sext imm << 2
//   alu_op   [4:0]  ADD=0, SUB=1, AND=2, OR=3, SLT=4
//   ALURegWe        ALU result-latch enable
//   PCWrite, PCSource[1:0], IorD, MemRead, MemWrite, IRWrite,
//   MemtoReg, RegDst, RegWrite  datapath controls
//   state    [3:0]  current state code
//   illegal         one-cycle pulse on an unsupported opcode or funct
//
// Modports
//   master  the control FSM (consumes decode/status, drives controls)
//   slave   the datapath side (drives decode/status, consumes controls)
// -----------------------------------------------------------------------------
interface mc_control_fsm_if;
   logic [5:0] opcode;
   logic [5:0] funct;
   logic       flag;
   logic       ALUSrcA;
   logic [1:0] ALUSrcB;
   logic [4:0] alu_op;
   logic       ALURegWe;
   logic       PCWrite;
   logic [1:0] PCSource;
   logic       IorD;
   logic       MemRead;
   logic       MemWrite;
   logic       IRWrite;
   logic       MemtoReg;
   logic       RegDst;
   logic       RegWrite;
   logic [3:0] state;
   logic       illegal;

   modport master (
      input  opcode, funct, flag,
      output ALUSrcA, ALUSrcB, alu_op, ALURegWe, PCWrite, PCSource, IorD,
             MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite, state, illegal
   );

   modport slave (
      output opcode, funct, flag,
      input  ALUSrcA, ALUSrcB, alu_op, ALURegWe, PCWrite, PCSource, IorD,
             MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite, state, illegal
   );
endinterface

// File: rtl/mc_control_fsm.sv
// -----------------------------------------------------------------------------
// mc_control_fsm
// Control unit of a multi-cycle MIPS-style processor. Sequences lw, sw,
// R-type (add/sub/and/or/slt), beq, j and addi through a 12-state FSM. All
// outputs are combinational decodes of the state register and the inputs.
//
// Ports
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    mc_control_fsm_if.master (decode inputs, ALU flag, control outputs)
//
// Configuration
//   BNE_EN  when defined, opcode 0x05 (bne) is decoded to BRANCH and takes the
//           branch on ~flag; when undefined, 0x05 is an illegal opcode.
// -----------------------------------------------------------------------------
module mc_control_fsm (
   input  logic             clk,
   input  logic             rst_n,
   mc_control_fsm_if.master bus
);

   // Opcodes
   localparam logic [5:0] OpRtype = 6'h00;
   localparam logic [5:0] OpJ     = 6'h02;
   localparam logic [5:0] OpBeq   = 6'h04;
`ifdef BNE_EN
   localparam logic [5:0] OpBne   = 6'h05;
`endif
   localparam logic [5:0] OpAddi  = 6'h08;
   localparam logic [5:0] OpLw    = 6'h23;
   localparam logic [5:0] OpSw    = 6'h2B;

   // R-type funct codes
   localparam logic [5:0] FnAdd = 6'h20;
   localparam logic [5:0] FnSub = 6'h22;
   localparam logic [5:0] FnAnd = 6'h24;
   localparam logic [5:0] FnOr  = 6'h25;
   localparam logic [5:0] FnSlt = 6'h2A;

   // ALU operation encoding
   localparam logic [4:0] AluAdd = 5'h00;
   localparam logic [4:0] AluSub = 5'h01;
   localparam logic [4:0] AluAnd = 5'h02;
   localparam logic [4:0] AluOr  = 5'h03;
   localparam logic [4:0] AluSlt = 5'h04;

   typedef enum logic [3:0] {
      StFetch  = 4'd0,
      StDecode = 4'd1,
      StMemAdr = 4'd2,
      StMemRd  = 4'd3,
      StMemWb  = 4'd4,
      StMemWr  = 4'd5,
      StExec   = 4'd6,
      StRwb    = 4'd7,
      StBranch = 4'd8,
      StJump   = 4'd9,
      StIExec  = 4'd10,
      StIwb    = 4'd11
   } state_e;

   state_e     r_state;
   state_e     w_state_nxt;
   // Cleared by reset, set on the first clock edge after release; the first
   // FETCH cycle starts on that edge, and all controls stay low until then.
   logic       r_run;

   logic       w_alu_src_a;
   logic [1:0] w_alu_src_b;
   logic [4:0] w_alu_op;
   logic       w_alu_reg_we;
   logic       w_pc_write;
   logic [1:0] w_pc_source;
   logic       w_iord;
   logic       w_mem_read;
   logic       w_mem_write;
   logic       w_ir_write;
   logic       w_mem_to_reg;
   logic       w_reg_dst;
   logic       w_reg_write;
   logic       w_illegal;

   // ---------------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= StFetch;
         r_run   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_run   <= 1'b1;
      end
   end

   // ---------------------------------------------------------------------------
   // Next-state and output decode
   // ---------------------------------------------------------------------------
   always_comb begin
      w_state_nxt  = StFetch;
      w_alu_src_a  = 1'b0;
      w_alu_src_b  = 2'd0;
      w_alu_op     = AluAdd;
      w_alu_reg_we = 1'b0;
      w_pc_write   = 1'b0;
      w_pc_source  = 2'd0;
      w_iord       = 1'b0;
      w_mem_read   = 1'b0;
      w_mem_write  = 1'b0;
      w_ir_write   = 1'b0;
      w_mem_to_reg = 1'b0;
      w_reg_dst    = 1'b0;
      w_reg_write  = 1'b0;
      w_illegal    = 1'b0;

      case (r_state)
         StFetch: begin
            w_mem_read  = 1'b1;
            w_ir_write  = 1'b1;
            w_alu_src_b = 2'd1;
            w_pc_write  = 1'b1;
            w_state_nxt = StDecode;
         end

         StDecode: begin
            // Precompute PC + (imm << 2) so BRANCH can use the latched target.
            w_alu_src_b  = 2'd3;
            w_alu_reg_we = 1'b1;
            case (bus.opcode)
               OpLw, OpSw: w_state_nxt = StMemAdr;
               OpRtype:    w_state_nxt = StExec;
               OpBeq:      w_state_nxt = StBranch;
`ifdef BNE_EN
               OpBne:      w_state_nxt = StBranch;
`endif
               OpJ:        w_state_nxt = StJump;
               OpAddi:     w_state_nxt = StIExec;
               default: begin
                  w_illegal   = 1'b1;
                  w_state_nxt = StFetch;
               end
            endcase
         end

         StMemAdr: begin
            w_alu_src_a  = 1'b1;
            w_alu_src_b  = 2'd2;
            w_alu_reg_we = 1'b1;
            if (bus.opcode == OpLw) begin
               w_state_nxt = StMemRd;
            end else if (bus.opcode == OpSw) begin
               w_state_nxt = StMemWr;
            end else begin
               w_state_nxt = StFetch;
            end
         end

         StMemRd: begin
            w_mem_read  = 1'b1;
            w_iord      = 1'b1;
            w_state_nxt = StMemWb;
         end

         StMemWb: begin
            w_reg_write  = 1'b1;
            w_mem_to_reg = 1'b1;
            w_state_nxt  = StFetch;
         end

         StMemWr: begin
            w_mem_write = 1'b1;
            w_iord      = 1'b1;
            w_state_nxt = StFetch;
         end

         StExec: begin
            w_alu_src_a  = 1'b1;
            w_alu_reg_we = 1'b1;
            w_state_nxt  = StRwb;
            case (bus.funct)
               FnAdd: w_alu_op = AluAdd;
               FnSub: w_alu_op = AluSub;
               FnAnd: w_alu_op = AluAnd;
               FnOr:  w_alu_op = AluOr;
               FnSlt: w_alu_op = AluSlt;
               default: begin
                  // Skip RWB so nothing reaches the register file.
                  w_illegal   = 1'b1;
                  w_state_nxt = StFetch;
               end
            endcase
         end

         StRwb: begin
            w_reg_write = 1'b1;
            w_reg_dst   = 1'b1;
            w_state_nxt = StFetch;
         end

         StBranch: begin
            w_alu_src_a = 1'b1;
            w_alu_op    = AluSub;
            w_pc_source = 2'd1;
`ifdef BNE_EN
            w_pc_write  = (bus.opcode == OpBne) ? ~bus.flag : bus.flag;
`else
            w_pc_write  = bus.flag;
`endif
            w_state_nxt = StFetch;
         end

         StJump: begin
            w_pc_source = 2'd2;
            w_pc_write  = 1'b1;
            w_state_nxt = StFetch;
         end

         StIExec: begin
            w_alu_src_a  = 1'b1;
            w_alu_src_b  = 2'd2;
            w_alu_reg_we = 1'b1;
            w_state_nxt  = StIwb;
         end

         StIwb: begin
            w_reg_write = 1'b1;
            w_state_nxt = StFetch;
         end

         default: w_state_nxt = StFetch;
      endcase

      // Held in FETCH with every control low during reset and until the first
      // edge after release.
      if (!r_run) begin
         w_state_nxt  = StFetch;
         w_alu_src_a  = 1'b0;
         w_alu_src_b  = 2'd0;
         w_alu_op     = AluAdd;
         w_alu_reg_we = 1'b0;
         w_pc_write   = 1'b0;
         w_pc_source  = 2'd0;
         w_iord       = 1'b0;
         w_mem_read   = 1'b0;
         w_mem_write  = 1'b0;
         w_ir_write   = 1'b0;
         w_mem_to_reg = 1'b0;
         w_reg_dst    = 1'b0;
         w_reg_write  = 1'b0;
         w_illegal    = 1'b0;
      end
   end

   assign bus.ALUSrcA  = w_alu_src_a;
   assign bus.ALUSrcB  = w_alu_src_b;
   assign bus.alu_op   = w_alu_op;
   assign bus.ALURegWe = w_alu_reg_we;
   assign bus.PCWrite  = w_pc_write;
   assign bus.PCSource = w_pc_source;
   assign bus.IorD     = w_iord;
   assign bus.MemRead  = w_mem_read;
   assign bus.MemWrite = w_mem_write;
   assign bus.IRWrite  = w_ir_write;
   assign bus.MemtoReg = w_mem_to_reg;
   assign bus.RegDst   = w_reg_dst;
   assign bus.RegWrite = w_reg_write;
   assign bus.state    = r_state;
   assign bus.illegal  = w_illegal;

endmodule

// File: tb/tb_mc_control_fsm.sv
// -----------------------------------------------------------------------------
// tb_mc_control_fsm
// Drives directed instruction sequences into mc_control_fsm. For each cycle
// the driver pushes the expected output vector into a queue; an independent
// monitor pops one entry per sampled cycle (each falling clk edge, and on an
// asynchronous reset assertion) and compares the full output vector.
// -----------------------------------------------------------------------------
module tb_mc_control_fsm;

   typedef struct packed {
      logic [3:0] state;
      logic       src_a;
      logic [1:0] src_b;
      logic [4:0] alu_op;
      logic       alu_we;
      logic       pc_write;
      logic [1:0] pc_src;
      logic       iord;
      logic       mem_rd;
      logic       mem_wr;
      logic       ir_wr;
      logic       m2r;
      logic       rdst;
      logic       reg_wr;
      logic       ill;
   } rec_t;

   logic clk = 1'b0;
   logic rst_n;
   logic stim_done = 1'b0;

   rec_t  exp_q[$];
   string tag_q[$];
   int    total = 0;
   int    bad   = 0;

   always #5 clk = ~clk;

   mc_control_fsm_if bus ();

   mc_control_fsm u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Expected outputs per state; input-dependent fields are passed in.
   function automatic rec_t exp_rec(input logic [3:0] st, input logic [4:0] aop,
                                    input logic pcw, input logic ill);
      rec_t r;
      r       = '0;
      r.state = st;
      case (st)
         4'd0:  begin r.mem_rd = 1; r.ir_wr = 1; r.src_b = 2'd1; r.pc_write = 1; end
         4'd1:  begin r.src_b = 2'd3; r.alu_we = 1; r.ill = ill; end
         4'd2:  begin r.src_a = 1; r.src_b = 2'd2; r.alu_we = 1; end
         4'd3:  begin r.mem_rd = 1; r.iord = 1; end
         4'd4:  begin r.reg_wr = 1; r.m2r = 1; end
         4'd5:  begin r.mem_wr = 1; r.iord = 1; end
         4'd6:  begin r.src_a = 1; r.alu_op = aop; r.alu_we = 1; r.ill = ill; end
         4'd7:  begin r.reg_wr = 1; r.rdst = 1; end
         4'd8:  begin r.src_a = 1; r.alu_op = 5'h01; r.pc_src = 2'd1; r.pc_write = pcw; end
         4'd9:  begin r.pc_src = 2'd2; r.pc_write = 1; end
         4'd10: begin r.src_a = 1; r.src_b = 2'd2; r.alu_we = 1; end
         4'd11: begin r.reg_wr = 1; end
         default: ;
      endcase
      return r;
   endfunction

   task automatic push(input rec_t r, input string t);
      exp_q.push_back(r);
      tag_q.push_back(t);
   endtask

   task automatic ps(input logic [3:0] st, input string t);
      push(exp_rec(st, 5'h00, 1'b0, 1'b0), t);
   endtask

   task automatic set_in(input logic [5:0] op, input logic [5:0] fn, input logic fl);
      bus.opcode = op;
      bus.funct  = fn;
      bus.flag   = fl;
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // ---------------------------------------------------------------------------
   // Monitor / scoreboard
   // ---------------------------------------------------------------------------
   initial begin
      rec_t  e;
      rec_t  a;
      string t;
      int    wakes;
      wakes = 0;
      #2;
      forever begin
         @(negedge clk or negedge rst_n);
         #1;
         wakes++;
         if (exp_q.size() > 0) begin
            e        = exp_q.pop_front();
            t        = tag_q.pop_front();
            a.state  = bus.state;
            a.src_a  = bus.ALUSrcA;
            a.src_b  = bus.ALUSrcB;
            a.alu_op = bus.alu_op;
            a.alu_we = bus.ALURegWe;
            a.pc_write = bus.PCWrite;
            a.pc_src = bus.PCSource;
            a.iord   = bus.IorD;
            a.mem_rd = bus.MemRead;
            a.mem_wr = bus.MemWrite;
            a.ir_wr  = bus.IRWrite;
            a.m2r    = bus.MemtoReg;
            a.rdst   = bus.RegDst;
            a.reg_wr = bus.RegWrite;
            a.ill    = bus.illegal;
            total++;
            if (a !== e) begin
               bad++;
               $display("FAIL %s: got %h want %h (state got %0d want %0d)",
                        t, a, e, a.state, e.state);
            end
         end else if (stim_done) begin
            $display("test done: total=%0d bad=%0d", total, bad);
            $finish;
         end
         if (wakes > 2000) begin
            bad++;
            $display("FAIL watchdog: got pending=%0d want 0", exp_q.size());
            $display("test done: total=%0d bad=%0d", total, bad);
            $finish;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Stimulus
   // ---------------------------------------------------------------------------
   logic [5:0] fn_tab [5];
   logic [4:0] aop_tab[5];

   initial begin
      fn_tab  = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
      aop_tab = '{5'h00, 5'h01, 5'h02, 5'h03, 5'h04};
      rst_n = 1'b0;
      set_in(6'h00, 6'h00, 1'b0);

      // Sampled with reset held, then after release but before the first edge.
      push('0, "rst_hold");
      push('0, "rst_release_pre_edge");
      #17 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // lw: 0,1,2,3,4
      set_in(6'h23, 6'h00, 1'b0);
      ps(0, "lw_fetch"); ps(1, "lw_decode"); ps(2, "lw_memadr");
      ps(3, "lw_memrd"); ps(4, "lw_memwb");
      step(5);

      // sw: 0,1,2,5
      set_in(6'h2B, 6'h00, 1'b0);
      ps(0, "sw_fetch"); ps(1, "sw_decode"); ps(2, "sw_memadr"); ps(5, "sw_memwr");
      step(4);

      // R-type, each supported funct
      for (int i = 0; i < 5; i++) begin
         set_in(6'h00, fn_tab[i], 1'b0);
         ps(0, $sformatf("r%0h_fetch", fn_tab[i]));
         ps(1, $sformatf("r%0h_decode", fn_tab[i]));
         push(exp_rec(4'd6, aop_tab[i], 1'b0, 1'b0), $sformatf("r%0h_exec", fn_tab[i]));
         ps(7, $sformatf("r%0h_rwb", fn_tab[i]));
         step(4);
      end

      // R-type with unsupported funct: illegal in EXEC, straight back to FETCH
      set_in(6'h00, 6'h3F, 1'b0);
      ps(0, "rbad_fetch"); ps(1, "rbad_decode");
      push(exp_rec(4'd6, 5'h00, 1'b0, 1'b1), "rbad_exec");
      step(3);

      // beq taken, then not taken
      set_in(6'h04, 6'h00, 1'b1);
      ps(0, "beq1_fetch"); ps(1, "beq1_decode");
      push(exp_rec(4'd8, 5'h00, 1'b1, 1'b0), "beq1_branch");
      step(3);
      set_in(6'h04, 6'h00, 1'b0);
      ps(0, "beq0_fetch"); ps(1, "beq0_decode");
      push(exp_rec(4'd8, 5'h00, 1'b0, 1'b0), "beq0_branch");
      step(3);

      // j
      set_in(6'h02, 6'h00, 1'b0);
      ps(0, "j_fetch"); ps(1, "j_decode"); ps(9, "j_jump");
      step(3);

      // addi
      set_in(6'h08, 6'h00, 1'b0);
      ps(0, "addi_fetch"); ps(1, "addi_decode"); ps(10, "addi_iexec"); ps(11, "addi_iwb");
      step(4);

      // unsupported opcode
      set_in(6'h3F, 6'h00, 1'b0);
      ps(0, "opbad_fetch");
      push(exp_rec(4'd1, 5'h00, 1'b0, 1'b1), "opbad_decode");
      step(2);

      // bne
`ifdef BNE_EN
      set_in(6'h05, 6'h00, 1'b0);
      ps(0, "bne0_fetch"); ps(1, "bne0_decode");
      push(exp_rec(4'd8, 5'h00, 1'b1, 1'b0), "bne0_branch");
      step(3);
      set_in(6'h05, 6'h00, 1'b1);
      ps(0, "bne1_fetch"); ps(1, "bne1_decode");
      push(exp_rec(4'd8, 5'h00, 1'b0, 1'b0), "bne1_branch");
      step(3);
`else
      set_in(6'h05, 6'h00, 1'b0);
      ps(0, "bne_fetch");
      push(exp_rec(4'd1, 5'h00, 1'b0, 1'b1), "bne_decode_illegal");
      step(2);
`endif

      // sw interrupted by reset while in MEMWR
      set_in(6'h2B, 6'h00, 1'b0);
      ps(0, "swr_fetch"); ps(1, "swr_decode"); ps(2, "swr_memadr"); ps(5, "swr_memwr");
      step(3);
      @(negedge clk);
      #2;
      push('0, "rst_async_in_memwr");
      push('0, "rst_mid_hold1");
      push('0, "rst_mid_hold2");
      push('0, "rst_mid_release_pre_edge");
      rst_n = 1'b0;
      @(posedge clk);
      @(posedge clk);
      @(posedge clk);
      #2 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // lw after recovery
      set_in(6'h23, 6'h00, 1'b0);
      ps(0, "lw2_fetch"); ps(1, "lw2_decode"); ps(2, "lw2_memadr");
      ps(3, "lw2_memrd"); ps(4, "lw2_memwb");
      step(5);

      stim_done = 1'b1;
   end

endmodule
